// File: rtl/dpram_copy_engine.sv
// Block copy / fill master for a true dual-port RAM: port A reads, port B writes,
// one word per clock. Copies run in the direction that makes overlapping moves memmove-safe.
module dpram_copy_engine #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          op,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [AW:0]   len,
    input  logic [DW-1:0] pattern,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] addr_a,
    output logic [DW-1:0] data_a,
    output logic          we_a,
    input  logic [DW-1:0] q_a,
    output logic [AW-1:0] addr_b,
    output logic [DW-1:0] data_b,
    output logic          we_b
);

    localparam logic [AW-1:0] AddrOne = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CntOne  = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e        state_q, state_d;
    logic          op_q, op_d;
    logic          desc_q, desc_d;
    logic [DW-1:0] pat_q, pat_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] addr_a_q, addr_a_d;
    logic [AW-1:0] addr_b_q, addr_b_d;
    logic          we_b_q, we_b_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [AW-1:0] step;
    logic [AW-1:0] len_m1;
    logic          go_desc;

    assign step    = desc_q ? {AW{1'b1}} : AddrOne;
    assign len_m1  = len[AW-1:0] - AddrOne;
    assign go_desc = dst > src;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            op_q     <= 1'b0;
            desc_q   <= 1'b0;
            pat_q    <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            we_b_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            desc_q   <= desc_d;
            pat_q    <= pat_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            we_b_q   <= we_b_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        desc_d   = desc_q;
        pat_d    = pat_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        we_b_d   = we_b_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    op_d   = op;
                    pat_d  = pattern;
                    cnt_d  = len;
                    busy_d = 1'b1;
                    if (len == '0) begin
                        // Empty command: pass through the drain slot so done lands one edge later.
                        state_d = StDrain;
                    end else if (op) begin
                        state_d  = StRun;
                        we_b_d   = 1'b1;
                        addr_b_d = dst;
                    end else begin
                        state_d  = StRun;
                        desc_d   = go_desc;
                        addr_a_d = go_desc ? src + len_m1 : src;
                        wr_ptr_d = go_desc ? dst + len_m1 : dst;
                    end
                end
            end
            StRun: begin
                if (op_q) begin
                    if (cnt_q == CntOne) begin
                        state_d = StDone;
                        we_b_d  = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        addr_b_d = addr_b_q + AddrOne;
                        cnt_d    = cnt_q - CntOne;
                    end
                end else begin
                    // Write the word whose read was issued last cycle; q_a is valid now.
                    we_b_d   = 1'b1;
                    addr_b_d = wr_ptr_q;
                    wr_ptr_d = wr_ptr_q + step;
                    cnt_d    = cnt_q - CntOne;
                    if (cnt_q == CntOne) begin
                        state_d = StDrain;
                    end else begin
                        addr_a_d = addr_a_q + step;
                    end
                end
            end
            StDrain: begin
                state_d = StDone;
                we_b_d  = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign addr_a = addr_a_q;
    assign data_a = '0;
    assign we_a   = 1'b0;
    assign addr_b = addr_b_q;
    assign we_b   = we_b_q;
    assign data_b = op_q ? pat_q : q_a;

endmodule

// File: tb/tb_dpram_copy_engine.sv
// Bench for dpram_copy_engine: behavioural RAM plus a memmove/fill reference memory,
// directed vector table, hand-written corner sequences and randomized commands.
module tb_dpram_copy_engine;

    logic        clk;
    logic        rst;
    logic        start;
    logic        op;
    logic [7:0]  src;
    logic [7:0]  dst;
    logic [8:0]  len;
    logic [15:0] pattern;
    logic        busy;
    logic        done;
    logic [7:0]  addr_a;
    logic [15:0] data_a;
    logic        we_a;
    logic [15:0] q_a;
    logic [7:0]  addr_b;
    logic [15:0] data_b;
    logic        we_b;

    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [15:0] ld_data;

    logic [15:0] mem [256];
    logic [15:0] ref_mem [256];

    int total = 0;
    int bad = 0;
    bit we_a_seen = 0;
    bit overlap_seen = 0;

    dpram_copy_engine #(.DW(16), .AW(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .src     (src),
        .dst     (dst),
        .len     (len),
        .pattern (pattern),
        .busy    (busy),
        .done    (done),
        .addr_a  (addr_a),
        .data_a  (data_a),
        .we_a    (we_a),
        .q_a     (q_a),
        .addr_b  (addr_b),
        .data_b  (data_b),
        .we_b    (we_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM: registered read on port A, write on port B, bench load port for preloading.
    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (we_b) mem[addr_b] <= data_b;
        q_a <= mem[addr_a];
    end

    always @(negedge clk) begin
        if (we_a) we_a_seen = 1'b1;
        if (busy && done) overlap_seen = 1'b1;
    end

    typedef struct {
        string       name;
        logic        o;
        logic [7:0]  s;
        logic [7:0]  d;
        logic [8:0]  l;
        logic [15:0] p;
        int          lat;
        int          wes;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic load(input int a, input logic [15:0] v);
        @(negedge clk);
        ld_en = 1'b1;
        ld_addr = 8'(a);
        ld_data = v;
        ref_mem[a] = v;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic check_mem(input string name);
        int bad_addr;
        bad_addr = -1;
        for (int a = 0; a < 256; a++)
            if (mem[a] !== ref_mem[a] && bad_addr < 0) bad_addr = a;
        total++;
        if (bad_addr >= 0) begin
            bad++;
            $display("FAIL %s: mem[0x%02h] got 0x%04h want 0x%04h", name, bad_addr,
                     mem[bad_addr], ref_mem[bad_addr]);
        end
    endtask

    // memmove / memset semantics with plain index arithmetic.
    task automatic apply_ref(input logic o, input logic [7:0] s, input logic [7:0] d,
                             input logic [8:0] l, input logic [15:0] p);
        logic [15:0] tmp [256];
        for (int k = 0; k < int'(l); k++) tmp[k] = ref_mem[(int'(s) + k) % 256];
        for (int k = 0; k < int'(l); k++) ref_mem[(int'(d) + k) % 256] = o ? p : tmp[k];
    endtask

    // Returns at the negedge where done is observed (k counts edges after the accept edge).
    task automatic run_op(input logic o, input logic [7:0] s, input logic [7:0] d,
                          input logic [8:0] l, input logic [15:0] p, input int glitch,
                          output int lat, output int wes, output int busys);
        lat = -1;
        wes = 0;
        busys = 0;
        @(negedge clk);
        op = o; src = s; dst = d; len = l; pattern = p; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Changing inputs after acceptance must not matter.
        op = ~o; src = ~s; dst = ~d; len = ~l; pattern = ~p;
        for (int k = 0; k < 400; k++) begin
            if (k > 0) @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
            if (busy) busys++;
            if (we_b) wes++;
            start = (k == glitch);
        end
        start = 1'b0;
    endtask

    task automatic do_op(input string name, input logic o, input logic [7:0] s,
                         input logic [7:0] d, input logic [8:0] l, input logic [15:0] p,
                         input int glitch, input int exp_lat, input int exp_wes);
        int lat, wes, busys;
        run_op(o, s, d, l, p, glitch, lat, wes, busys);
        apply_ref(o, s, d, l, p);
        chk({name, "_done_lat"}, lat, exp_lat);
        chk({name, "_we_cycles"}, wes, exp_wes);
        chk({name, "_busy_cycles"}, busys, exp_lat);
        check_mem({name, "_mem"});
    endtask

    initial begin
        int nd, ok;
        int l, s, d;
        logic o;

        vecs[0] = '{"copy4",    1'b0, 8'h10, 8'h40, 9'd4,   16'h0000, 5,   4};
        vecs[1] = '{"overlap",  1'b0, 8'h10, 8'h12, 9'd4,   16'h0000, 5,   4};
        vecs[2] = '{"fillwrap", 1'b1, 8'h00, 8'hFE, 9'd4,   16'hBEEF, 4,   4};
        vecs[3] = '{"len0",     1'b0, 8'h20, 8'h30, 9'd0,   16'h0000, 1,   0};
        vecs[4] = '{"len256",   1'b0, 8'h00, 8'h00, 9'd256, 16'h0000, 257, 256};

        rst = 1'b1; start = 1'b0; op = 1'b0; src = '0; dst = '0; len = '0; pattern = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_we_b", int'(we_b), 0);
        chk("rst_addr_a", int'(addr_a), 0);
        chk("rst_addr_b", int'(addr_b), 0);
        chk("rst_data_a", int'(data_a), 0);

        for (int a = 0; a < 256; a++) load(a, 16'($urandom));
        for (int a = 0; a < 4; a++) load(16 + a, 16'(a + 1));

        for (int i = 0; i < 5; i++)
            do_op(vecs[i].name, vecs[i].o, vecs[i].s, vecs[i].d, vecs[i].l, vecs[i].p, -1,
                  vecs[i].lat, vecs[i].wes);
        chk("copy4_word40", int'(mem[8'h40]), 1);
        chk("overlap_word15", int'(mem[8'h15]), 4);
        chk("fill_word00", int'(mem[8'h00]), 16'hBEEF);

        // start while busy and during the done cycle must be ignored.
        for (int a = 0; a < 4; a++) load(16 + a, 16'(a + 1));
        do_op("glitch", 1'b0, 8'h10, 8'h60, 9'd4, 16'h0, 2, 5, 4);
        op = 1'b1; dst = 8'h60; len = 9'd4; pattern = 16'hDEAD; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nd = int'(busy);
        @(negedge clk);
        nd = nd + int'(busy) + int'(we_b);
        chk("start_in_done_ignored", nd, 0);
        check_mem("glitch_after_mem");

        // Reset mid-fill: accept edge E0, writes at E1 and E2, reset applied at E2.
        @(negedge clk);
        op = 1'b1; dst = 8'h80; len = 9'd8; pattern = 16'h1234; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_we_b", int'(we_b), 0);
        nd = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done || we_b) nd++;
        end
        chk("midrst_no_done", nd, 0);
        ref_mem[8'h80] = 16'h1234;
        ref_mem[8'h81] = 16'h1234;
        check_mem("midrst_mem");

        for (int i = 0; i < 20; i++) begin
            o = 1'($urandom_range(0, 1));
            l = $urandom_range(0, 40);
            if (o) begin
                s = 0;
                d = $urandom_range(0, 255);
            end else begin
                s = $urandom_range(0, 256 - l);
                if ($urandom_range(0, 1) == 1) begin
                    d = s + $urandom_range(0, 16) - 8;
                    if (d < 0) d = 0;
                    if (d > 256 - l) d = 256 - l;
                end else begin
                    d = $urandom_range(0, 256 - l);
                end
            end
            ok = (l == 0) ? 1 : (o ? l : l + 1);
            do_op($sformatf("rnd%0d", i), o, 8'(s), 8'(d), 9'(l), 16'($urandom), -1, ok, l);
        end

        chk("we_a_never", int'(we_a_seen), 0);
        chk("busy_done_overlap", int'(overlap_seen), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
